pattern_streamer: RTL

Single-clock, parametrised pattern-to-sensor streamer: loads `num_pat` wide pattern words from the upstream pattern FIFO into an internal buffer, then serialises each word into `IN_W/OUT_W` narrow slices, one per `stream_en_i` cycle, onto the sensor MSTREAM lines. Unlike the previous generation, it replays the buffer in loop mode, checks word count against buffer depth, and flags underruns. It sits between the pattern FIFO read port and the sensor output drivers.

---
 rtl/pattern_streamer_pkg.sv | 23 ++
 rtl/pattern_streamer_if.sv | 28 ++
 rtl/pattern_streamer_buffer.sv | 24 ++
 rtl/pattern_streamer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_streamer_pkg.sv
// Shared types and sizing helpers for the pattern streamer slice.
package pattern_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam int PASS_W = 16;

  function automatic int ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // A single-slice word still needs a 1-bit slice counter.
  function automatic int slice_bits(input int r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/pattern_streamer_if.sv
// Upstream pattern FIFO read port plus the sensor-side slice stream.
interface pattern_streamer_if #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 64,
  parameter int NCH   = 20
);

  logic [IN_W-1:0]  pat_in;
  logic             pat_empty;
  logic             pat_valid;
  logic             pat_rd_en;
  logic             stream_en_i;
  logic             stream_en_o;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic [NCH-1:0]   mstream_out;

  modport master (
    output pat_in, pat_empty, pat_valid, stream_en_i,
    input  pat_rd_en, stream_en_o, dout, dout_valid, mstream_out
  );

  modport slave (
    input  pat_in, pat_empty, pat_valid, stream_en_i,
    output pat_rd_en, stream_en_o, dout, dout_valid, mstream_out
  );

endinterface

// File: rtl/pattern_streamer_buffer.sv
// Simple dual-port pattern buffer: one write port, one synchronous read port.
module pattern_buffer_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pattern_streamer.sv
// Loads pattern words into a local buffer, then replays them as narrow
// slices on the sensor stream, single-pass or looping.
module pattern_streamer
  import pattern_streamer_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int OUT_W = 64,
  parameter int NCH   = 20,
  parameter int DEPTH = 1024,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_loop,
  input  logic              stop,
  input  logic [CNT_W-1:0]  num_pat,
  pattern_streamer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              err_clamp,
  output logic [PASS_W-1:0] pass_cnt
);

  localparam int RATIO = ratio(IN_W, OUT_W);
  localparam int SL_W  = slice_bits(RATIO);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = AW + 1;

  state_t                      state;
  logic                        loop_q;
  logic                        stop_seen;
  logic                        drain;
  logic [PTR_W-1:0]            n_q;
  logic [PTR_W-1:0]            issued;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            rd_ptr_nxt;
  logic [SL_W-1:0]             slice;
  logic [SL_W-1:0]             slice_nxt;
  logic [IN_W-1:0]             rd_word;
  logic [RATIO-1:0][OUT_W-1:0] word_slices;
  logic [OUT_W-1:0]            dout_q;
  logic                        dout_valid_q;
  logic                        stream_en_q;

  logic             start_ok;
  logic             clamp_start;
  logic [PTR_W-1:0] n_start;
  logic             fire;
  logic             last_slice;
  logic             last_word;
  logic             pass_end;
  logic             keep_looping;
  logic             rd_en_int;
  logic             buf_we;

  assign start_ok     = start && (state == ST_IDLE || state == ST_DONE);
  assign clamp_start  = (num_pat > CNT_W'(DEPTH));
  assign n_start      = clamp_start ? PTR_W'(DEPTH) : PTR_W'(num_pat);
  assign fire         = bus.stream_en_i &&
                        (state == ST_READY || (state == ST_STREAM && !drain));
  assign last_slice   = (slice == SL_W'(RATIO - 1));
  assign last_word    = (rd_ptr == n_q - PTR_W'(1));
  assign pass_end     = fire && last_slice && last_word;
  assign keep_looping = loop_q && !(stop_seen || stop);
  assign rd_en_int    = (state == ST_LOAD) && !bus.pat_empty && (issued < n_q);
  assign buf_we       = (state == ST_LOAD) && bus.pat_valid && (wr_ptr < n_q);
  assign word_slices  = rd_word;

  assign bus.pat_rd_en   = rd_en_int;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.stream_en_o = stream_en_q;
  assign bus.mstream_out = dout_q[NCH-1:0];
  assign busy            = (state == ST_LOAD) || (state == ST_STREAM);
  assign done            = (state == ST_DONE);

  // The RAM read address runs one step ahead of rd_ptr so the word being
  // sliced is already on rdata, including across word and loop boundaries.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    slice_nxt  = slice;
    if (reset || start_ok) begin
      rd_ptr_nxt = '0;
      slice_nxt  = '0;
    end else if (fire) begin
      slice_nxt = last_slice ? '0 : slice + SL_W'(1);
      if (last_slice) begin
        rd_ptr_nxt = last_word ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  pattern_buffer_ram #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.pat_in),
    .raddr (rd_ptr_nxt[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      loop_q       <= 1'b0;
      stop_seen    <= 1'b0;
      drain        <= 1'b0;
      n_q          <= '0;
      issued       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      slice        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      stream_en_q  <= 1'b0;
      underrun     <= 1'b0;
      err_clamp    <= 1'b0;
      pass_cnt     <= '0;
    end else begin
      rd_ptr       <= rd_ptr_nxt;
      slice        <= slice_nxt;
      stream_en_q  <= bus.stream_en_i;
      dout_valid_q <= fire;
      underrun     <= bus.stream_en_i && !fire;
      if (fire) begin
        dout_q <= word_slices[slice];
      end
      if (pass_end && pass_cnt != '1) begin
        pass_cnt <= pass_cnt + PASS_W'(1);
      end
      if (stop && (state == ST_LOAD || state == ST_READY || state == ST_STREAM)) begin
        stop_seen <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            loop_q    <= mode_loop;
            n_q       <= n_start;
            err_clamp <= clamp_start;
            pass_cnt  <= '0;
            issued    <= '0;
            wr_ptr    <= '0;
            stop_seen <= 1'b0;
            drain     <= 1'b0;
            state     <= (n_start == '0) ? ST_DONE : ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (rd_en_int) begin
            issued <= issued + PTR_W'(1);
          end
          if (buf_we) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          // Leaving only once all words are written gives the RAM one cycle
          // to present word 0 before READY.
          if (wr_ptr == n_q) begin
            state <= ST_READY;
          end
        end

        ST_READY, ST_STREAM: begin
          // The drain cycle lets the final slice show before done rises.
          if (drain) begin
            drain <= 1'b0;
            state <= ST_DONE;
          end else if (pass_end) begin
            state <= ST_STREAM;
            if (keep_looping) begin
              stop_seen <= 1'b0;
            end else begin
              drain <= 1'b1;
            end
          end else if (fire) begin
            state <= ST_STREAM;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
